// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_DM = 1'b1;
   function automatic int cnt_width(input int lat);
      return $clog2(lat + 1);
   endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              owner;
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the requester that was not served last wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       grant_valid,
   output logic       grant_id
);
   always_comb begin
      grant_valid = |req;
      grant_id    = &req ? ~last_owner : req[OWNER_DM];
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store accesses onto one single-port memory
// with round-robin fairness and a fixed MEM_LAT read latency.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = cnt_width(MEM_LAT);
   state_t            state_q, state_d;
   logic              owner_q, last_q, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;
   logic [CW-1:0]     cnt_q;
   logic [1:0]        req;
   logic              gv, gid, last_wait;
   // The requester just acked in RESP is masked so the other side gets the next slot.
   assign req = state_q == IDLE ? {bus.dm_req, bus.if_req} :
                state_q == RESP ? (owner_q == OWNER_IF ? {bus.dm_req, 1'b0} : {1'b0, bus.if_req}) :
                2'b00;
   assign last_wait = state_q == WAIT && cnt_q == CW'(1);
   rr_pick2 u_pick (
      .req         (req),
      .last_owner  (last_q),
      .grant_valid (gv),
      .grant_id    (gid)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb begin
      state_d = state_q == ISSUE ? WAIT :
                state_q == WAIT  ? (last_wait ? RESP : WAIT) :
                gv ? ISSUE : IDLE;
   end
   always_comb begin
      bus.mem_en = state_q == ISSUE;
      bus.if_ack = state_q == RESP && owner_q == OWNER_IF;
      bus.dm_ack = state_q == RESP && owner_q == OWNER_DM;
      bus.busy   = state_q != IDLE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         owner_q    <= OWNER_IF;
         last_q     <= OWNER_DM;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if (gv) begin
            owner_q <= gid;
            addr_q  <= gid == OWNER_DM ? bus.dm_addr : bus.if_addr;
            we_q    <= gid == OWNER_DM && bus.dm_we;
            wdata_q <= gid == OWNER_DM ? bus.dm_wdata : wdata_q;
         end
         if (state_q == RESP) last_q <= owner_q;
         cnt_q <= state_q == ISSUE ? CW'(MEM_LAT) : state_q == WAIT ? cnt_q - CW'(1) : cnt_q;
         if (last_wait && !we_q && owner_q == OWNER_IF) if_rdata_q <= bus.mem_rdata;
         if (last_wait && !we_q && owner_q == OWNER_DM) dm_rdata_q <= bus.mem_rdata;
      end
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of two arbiters (MEM_LAT=1 and MEM_LAT=3) against
// small latency-accurate memory models that return a poison word outside the valid cycle.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   always #5 clk = ~clk;
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_a (.clk(clk), .reset(reset), .bus(a));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_b (.clk(clk), .reset(reset), .bus(b));
   function automatic logic [31:0] mem_init(input logic [31:0] addr);
      return addr == 32'h10 ? 32'h8C020004 : 32'hA5000000 | addr;
   endfunction
   bit          wv_a;
   logic [31:0] wa_a, wd_a, ad;
   bit          av;
   bit   [2:0]  bv;
   logic [31:0] bd [3];
   always @(posedge clk) begin
      av <= a.mem_en && !a.mem_we;
      ad <= wv_a && a.mem_addr == wa_a ? wd_a : mem_init(a.mem_addr);
      if (a.mem_en && a.mem_we) begin
         wv_a <= 1'b1;
         wa_a <= a.mem_addr;
         wd_a <= a.mem_wdata;
      end
      bv    <= {bv[1:0], b.mem_en && !b.mem_we};
      bd[0] <= mem_init(b.mem_addr);
      bd[1] <= bd[0];
      bd[2] <= bd[1];
   end
   assign a.mem_rdata = av ? ad : 32'hBAD0BAD0;
   assign b.mem_rdata = bv[2] ? bd[2] : 32'hBAD0BAD0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      reset = 1'b0;
      {a.if_req, a.dm_req, a.dm_we, b.if_req, b.dm_req, b.dm_we} = '0;
      {a.if_addr, a.dm_addr, a.dm_wdata, b.if_addr, b.dm_addr, b.dm_wdata} = '0;
      @(negedge clk);
      chk("rst_flags", {a.busy, a.mem_en, a.mem_we, a.if_ack, a.dm_ack, a.owner}, 6'b0);
      chk("rst_mem", {a.mem_addr, a.mem_wdata}, 64'h0);
      chk("rst_rdata", {a.if_rdata, a.dm_rdata}, 64'h0);
      chk("rst_b", {b.busy, b.mem_en, b.if_ack, b.dm_ack, b.owner}, 5'b0);
      reset = 1'b1;
      // fetch only, MEM_LAT=1
      a.if_req = 1'b1;
      a.if_addr = 32'h10;
      chk("f_c0_idle", a.busy, 1'b0);
      tick;
      chk("f_c1_issue", {a.mem_en, a.mem_we, a.busy, a.owner}, 4'b1010);
      chk("f_c1_addr", a.mem_addr, 32'h10);
      tick;
      chk("f_c2_wait", {a.mem_en, a.if_ack, a.dm_ack}, 3'b000);
      tick;
      chk("f_c3_ack", {a.if_ack, a.dm_ack}, 2'b10);
      chk("f_c3_rdata", a.if_rdata, 32'h8C020004);
      a.if_req = 1'b0;
      tick;
      chk("f_c4_idle", {a.if_ack, a.busy}, 2'b00);
      chk("f_c4_hold", a.if_rdata, 32'h8C020004);
      // tie straight after reset: fetch first
      reset = 1'b0;
      tick;
      reset = 1'b1;
      a.if_req = 1'b1;
      a.dm_req = 1'b1;
      a.dm_addr = 32'h40;
      a.if_addr = 32'h10;
      for (int c = 1; c <= 6; c++) begin
         tick;
         chk($sformatf("tie_c%0d", c), {a.if_ack, a.dm_ack, a.mem_en},
             c == 1 || c == 4 ? 3'b001 : c == 3 ? 3'b100 : c == 6 ? 3'b010 : 3'b000);
         if (c == 3) a.if_req = 1'b0;
      end
      chk("tie_dm_rdata", a.dm_rdata, 32'hA5000040);
      a.dm_req = 1'b0;
      tick;
      // sustained contention: IF, DM, IF, DM every 3 cycles
      a.if_req = 1'b1;
      a.dm_req = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick;
         chk($sformatf("cont_c%0d", c), {a.if_ack, a.dm_ack}, {c % 6 == 3, c % 6 == 0});
      end
      a.if_req = 1'b0;
      a.dm_req = 1'b0;
      tick;
      chk("cont_idle", a.busy, 1'b0);
      // write
      a.dm_req = 1'b1;
      a.dm_we = 1'b1;
      a.dm_addr = 32'h20;
      a.dm_wdata = 32'hDEADBEEF;
      tick;
      chk("w_c1_ctl", {a.mem_en, a.mem_we, a.owner}, 3'b111);
      chk("w_c1_bus", {a.mem_addr, a.mem_wdata}, {32'h20, 32'hDEADBEEF});
      tick;
      chk("w_c2_hold", {a.mem_en, a.mem_we, a.mem_addr}, {2'b01, 32'h20});
      tick;
      chk("w_c3_ack", {a.dm_ack, a.if_ack}, 2'b10);
      chk("w_c3_rdata", a.dm_rdata, 32'hA5000040);
      a.dm_req = 1'b0;
      a.dm_we = 1'b0;
      tick;
      a.if_req = 1'b1;
      a.if_addr = 32'h20;
      repeat (3) tick;
      chk("wr_readback", {a.if_ack, a.if_rdata}, {1'b1, 32'hDEADBEEF});
      a.if_req = 1'b0;
      tick;
      // MEM_LAT=3
      b.if_req = 1'b1;
      b.if_addr = 32'h10;
      for (int c = 1; c <= 5; c++) begin
         tick;
         chk($sformatf("lat3_c%0d", c), {b.if_ack, b.mem_en, b.busy},
             c == 1 ? 3'b011 : c == 5 ? 3'b101 : 3'b001);
      end
      chk("lat3_rdata", b.if_rdata, 32'h8C020004);
      b.if_req = 1'b0;
      tick;
      chk("lat3_idle", b.busy, 1'b0);
      // reset mid-WAIT on both arbiters
      a.if_req = 1'b1;
      a.if_addr = 32'h10;
      b.if_req = 1'b1;
      b.if_addr = 32'h40;
      tick;
      tick;
      chk("pre_rst_busy", {a.busy, b.busy}, 2'b11);
      reset = 1'b0;
      #1;
      chk("arst_a", {a.busy, a.mem_en, a.if_ack, a.dm_ack}, 4'b0);
      chk("arst_b", {b.busy, b.mem_en, b.if_ack, b.dm_ack}, 4'b0);
      chk("arst_b_rdata", b.if_rdata, 32'h0);
      a.if_req = 1'b0;
      b.if_req = 1'b0;
      tick;
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick;
         chk($sformatf("no_ack_%0d", c), {a.if_ack, a.dm_ack, b.if_ack, b.dm_ack, a.busy, b.busy}, 6'b0);
      end
      a.if_req = 1'b1;
      a.if_addr = 32'h10;
      tick;
      chk("post_c1", {a.mem_en, a.mem_addr}, {1'b1, 32'h10});
      tick;
      chk("post_c2", a.if_ack, 1'b0);
      tick;
      chk("post_c3", {a.if_ack, a.if_rdata}, {1'b1, 32'h8C020004});
      a.if_req = 1'b0;
      tick;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-way arbiter and sequencer for one shared single-port memory.
- Requesters: the instruction-fetch path (PC/instruction register side) and the load/store path (ALU-address/data side) of the multicycle datapath.
- Serialises their accesses with a req/ack handshake, round-robin fairness and a parameterised memory latency.
- The multicycle controller stalls on the ack signals.

Parameters:
- ADDR_W, 32, width of addresses on all ports.
- DATA_W, 32, width of data on all ports.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid. Must be >= 1; MEM_LAT = 0 is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse; fetch access done.
- if_rdata  out  DATA_W  fetched word, valid while if_ack=1 and held until the next fetch capture.
- dm_req  in  1  data request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_ack  out  1  one-cycle pulse; data access done.
- dm_rdata  out  DATA_W  load data, valid while dm_ack=1 after a read.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.
- owner  out  1  current or last grant: 0 = fetch, 1 = data.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs = 0. last_owner = 1 (data), so fetch wins the first tie. Wait counter = 0. Any in-flight access is abandoned with no ack; requesters must re-request.
- Requester rules:
  - req, addr, we and wdata stay stable from req assertion through the ack cycle inclusive.
  - After ack the requester may drop req, or keep req high with new fields as a new request.
- States:
  - IDLE: sample if_req and dm_req.
    - One active: grant it.
    - Both active: grant the one != last_owner.
    - On grant: latch addr/we/wdata (fetch: we=0), set owner, go to ISSUE.
  - ISSUE: mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values for exactly this cycle. Load counter = MEM_LAT. Go to WAIT.
  - WAIT: mem_en=0, counter decrements.
    - In the last WAIT cycle (MEM_LAT cycles after ISSUE), on a read, capture mem_rdata into the owner's rdata register.
    - On a write, neither rdata register changes.
    - Go to RESP.
  - RESP: owner's ack=1 for exactly one cycle; last_owner=owner.
    - The acked requester's req is ignored this cycle.
    - If the other requester's req=1, grant it (latch fields) and go to ISSUE.
    - Otherwise go to IDLE.
- Latency: req high in IDLE cycle c gives ISSUE at c+1 and ack at c+2+MEM_LAT (c+3 for the default).
- Continuous contention: accesses alternate fetch/data, one ack every MEM_LAT+2 cycles.
- if_ack and dm_ack are never high together. mem_en is high for exactly one cycle per access.
- mem_addr, mem_wdata and mem_we keep their last values outside ISSUE; mem_en qualifies them.
- Requests seen in ISSUE or WAIT are not granted until RESP or IDLE.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - OWNER_IF=1'b0 and OWNER_DM=1'b1;
  - counter width function clog2(MEM_LAT+1).
- One natural sub-module: rr_pick2, a combinational two-way round-robin picker. Inputs: req[1:0], last_owner. Outputs: grant_valid, grant_id.

Test Plan:
- MEM_LAT=1, fetch only: if_req=1, if_addr=0x10 at cycle 0, memory returns 0x8C020004 -> mem_en=1 with mem_addr=0x10 at cycle 1; if_ack=1 with if_rdata=0x8C020004 at cycle 3; dm_ack stays 0.
- Tie after reset: if_req=dm_req=1 at cycle 0 -> fetch acked at cycle 3, data access issued at cycle 4, dm_ack at cycle 6.
- Sustained contention: both reqs held high for 12 cycles -> acks in order IF, DM, IF, DM, spaced 3 cycles apart; never both high in one cycle.
- Write: dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF -> ISSUE cycle shows mem_we=1, mem_addr=0x20, mem_wdata=0xDEADBEEF; dm_ack 3 cycles after req; dm_rdata unchanged from its prior value.
- MEM_LAT=3: a read issued at cycle 1 has mem_rdata captured at the end of cycle 4 -> ack at cycle 5.
- Reset mid-WAIT: reset=0 asynchronously -> mem_en, acks and busy drop to 0 immediately, no ack afterwards; after release, a new if_req is served with the standard c+3 latency.
